id_issue_ctrl: RTL and testbench
================================

ID_ISSUE_CTRL -- requirements
Module: id_issue_ctrl

Interface
REQ-001 Parameter DATA_W, 32, register/PC data width.
REQ-002 Parameter AW, 5, register address width; NREG = 2^AW.
REQ-003 Parameter CNT_W, 2, per-register pending-write counter width; CMAX = 2^CNT_W-1.
REQ-004 Parameter NFWD, 3, forwarding port count; index 0 = youngest (EX), NFWD-1 = oldest (WB).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 resetn  in  1  reset, asynchronous, active-low.
REQ-007 in_valid/in_ready  in/out  1/1  upstream handshake (IF side); in_ready is the stage allow-in.
REQ-008 in_pc  in  DATA_W  PC of incoming instruction.
REQ-009 in_src1_en, in_src2_en  in  1 each  source operand used.
REQ-010 in_src1_addr, in_src2_addr, in_dst_addr  in  AW each  source/destination register.
REQ-011 in_dst_we  in  1  instruction writes in_dst_addr.
REQ-012 rf_raddr1, rf_raddr2  out  AW  = held src1/src2 addresses; rf_rdata1, rf_rdata2  in  DATA_W  same-cycle register-file data.
REQ-013 fwd_valid, fwd_ready  in  NFWD  per-port: write in flight / data available this cycle.
REQ-014 fwd_addr  in  NFWD*AW, fwd_data  in  NFWD*DATA_W  packed, port i at slice i.
REQ-015 wb_release/wb_addr  in  1/AW  one pulse per issued write, at register-file write.
REQ-016 flush  in  1  discard held instruction (branch cancel).
REQ-017 out_valid/out_ready  out/in  1/1  downstream handshake (EX side).
REQ-018 out_pc, out_src1, out_src2  out  DATA_W  held PC and resolved operands.
REQ-019 out_dst_we/out_dst_addr  out  1/AW  held destination.

Function
REQ-020 Holding register: loads all in_* fields when in_valid & in_ready; stage-valid v set then, else cleared on issue or flush.
REQ-021 Issue = out_valid & out_ready; in_ready = ~v | (ready_go & out_ready); zero-bubble back-to-back issue.
REQ-022 out_valid = v & ready_go & ~flush; flush with in_valid & in_ready same cycle: new instruction loads, v=1.
REQ-023 Scoreboard: NREG counters of CNT_W bits; register 0 never tracked, counter 0 stays 0.
REQ-024 On issue with out_dst_we & out_dst_addr!=0: counter[out_dst_addr] += 1.
REQ-025 On wb_release with wb_addr!=0: counter[wb_addr] -= 1; release on counter 0 is ignored (no wrap).
REQ-026 Issue increment and release decrement on same register same cycle: counter unchanged.
REQ-027 Operand resolve per source: addr==0 -> 0; else youngest port i with fwd_valid[i] & fwd_addr[i]==addr -> fwd_data[i]; else rf_rdata.
REQ-028 Source hazard: en & addr!=0 & (youngest match exists & ~fwd_ready[i], or no match & counter[addr]!=0).
REQ-029 Saturation hazard: out_dst_we & out_dst_addr!=0 & counter[out_dst_addr]==CMAX.
REQ-030 ready_go = v & ~(any source hazard) & ~saturation hazard; purely combinational, same-cycle.
REQ-031 Latency: operand data and out_valid combinational from held state; no added cycle when hazard-free.
REQ-032 Downstream stall (out_ready=0) holds all out_* stable, no counter change.
REQ-033 Environment contract: every issued write, including later-flushed ones, produces exactly one wb_release.

Reset
REQ-034 resetn low asynchronously clears v, all counters; out_valid=0, in_ready=1 during reset.
REQ-035 Reset mid-stall discards held instruction; held data fields need no reset.
REQ-036 First load permitted on the first rising edge after resetn deasserts.

Verification
REQ-037 Issue add r4 (dst_we) then held src1=r4, fwd port0 valid addr 4 ready, data 0x1234 -> out_src1=0x1234, no stall cycle.
REQ-038 Load-use: port0 valid addr 4 fwd_ready=0 for 1 cycle -> out_valid=0 one cycle, next cycle issues with port1 data.
REQ-039 Ports 0 and 2 both match r7 (data 0xA, 0xB) -> out_src=0xA; src addr 0 with matches -> out_src=0.
REQ-040 CNT_W=2: three issues to r5 without release -> fourth stalls until wb_release r5, then issues same cycle+1.
REQ-041 Flush while stalled on hazard -> out_valid=0, v cleared, counters unchanged; simultaneous issue+release r3 keeps counter.
REQ-042 Assert resetn low mid-operation with counters nonzero -> all counters 0, out_valid=0 immediately.

Source files
------------

// File: rtl/id_issue_ctrl_if.sv
// Upstream (IF side) and downstream (EX side) handshake bundle of the issue stage.
// The slave modport is the issue controller's view; master is the surrounding pipeline.
interface id_issue_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_pc;
    logic              in_src1_en;
    logic              in_src2_en;
    logic [AW-1:0]     in_src1_addr;
    logic [AW-1:0]     in_src2_addr;
    logic [AW-1:0]     in_dst_addr;
    logic              in_dst_we;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_pc;
    logic [DATA_W-1:0] out_src1;
    logic [DATA_W-1:0] out_src2;
    logic              out_dst_we;
    logic [AW-1:0]     out_dst_addr;

    modport slave (
        input  in_valid, in_pc, in_src1_en, in_src2_en,
               in_src1_addr, in_src2_addr, in_dst_addr, in_dst_we,
        output in_ready,
        output out_valid, out_pc, out_src1, out_src2, out_dst_we, out_dst_addr,
        input  out_ready
    );

    modport master (
        output in_valid, in_pc, in_src1_en, in_src2_en,
               in_src1_addr, in_src2_addr, in_dst_addr, in_dst_we,
        input  in_ready,
        input  out_valid, out_pc, out_src1, out_src2, out_dst_we, out_dst_addr,
        output out_ready
    );
endinterface

// File: rtl/id_issue_ctrl.sv
// Decode/issue stage: holds one instruction, resolves operands through forwarding,
// and stalls on RAW or pending-write-counter saturation hazards.
module id_issue_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned NFWD   = 3
) (
    input  logic                   clk,
    input  logic                   resetn,
    id_issue_ctrl_if.slave         bus,
    output logic [AW-1:0]          rf_raddr1,
    output logic [AW-1:0]          rf_raddr2,
    input  logic [DATA_W-1:0]      rf_rdata1,
    input  logic [DATA_W-1:0]      rf_rdata2,
    input  logic [NFWD-1:0]        fwd_valid,
    input  logic [NFWD-1:0]        fwd_ready,
    input  logic [NFWD*AW-1:0]     fwd_addr,
    input  logic [NFWD*DATA_W-1:0] fwd_data,
    input  logic                   wb_release,
    input  logic [AW-1:0]          wb_addr,
    input  logic                   flush
);
    localparam int unsigned NREG = 1 << AW;
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic {S_EMPTY, S_HELD} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] pc_q;
    logic              src1_en_q, src2_en_q, dst_we_q;
    logic [AW-1:0]     src1_addr_q, src2_addr_q, dst_addr_q;
    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];

    logic              in_fire, issue, ready_go, out_valid_c, in_ready_c, sat_haz;
    logic              src_en    [2];
    logic [AW-1:0]     src_addr  [2];
    logic [DATA_W-1:0] src_rf    [2];
    logic              m_hit     [2];
    logic              m_rdy     [2];
    logic [DATA_W-1:0] m_data    [2];
    logic              src_haz   [2];
    logic [DATA_W-1:0] src_val   [2];
    logic              inc_hit, dec_hit;

    assign src_en[0]   = src1_en_q;
    assign src_en[1]   = src2_en_q;
    assign src_addr[0] = src1_addr_q;
    assign src_addr[1] = src2_addr_q;
    assign src_rf[0]   = rf_rdata1;
    assign src_rf[1]   = rf_rdata2;

    // Youngest matching forward port wins: scan oldest to youngest so later hits override.
    always_comb begin
        for (int s = 0; s < 2; s++) begin
            m_hit[s]  = 1'b0;
            m_rdy[s]  = 1'b0;
            m_data[s] = '0;
            for (int i = int'(NFWD) - 1; i >= 0; i--) begin
                if (fwd_valid[i] && fwd_addr[i*AW +: AW] == src_addr[s]) begin
                    m_hit[s]  = 1'b1;
                    m_rdy[s]  = fwd_ready[i];
                    m_data[s] = fwd_data[i*DATA_W +: DATA_W];
                end
            end
            src_haz[s] = src_en[s] && (src_addr[s] != '0) &&
                         (m_hit[s] ? !m_rdy[s] : (cnt_q[src_addr[s]] != '0));
            if (src_addr[s] == '0)
                src_val[s] = '0;
            else if (m_hit[s])
                src_val[s] = m_data[s];
            else
                src_val[s] = src_rf[s];
        end
    end

    assign sat_haz     = dst_we_q && (dst_addr_q != '0) && (cnt_q[dst_addr_q] == CMAX);
    assign ready_go    = (state_q == S_HELD) && !src_haz[0] && !src_haz[1] && !sat_haz;
    assign out_valid_c = ready_go && !flush;
    assign issue       = out_valid_c && bus.out_ready;
    assign in_ready_c  = (state_q == S_EMPTY) || (ready_go && bus.out_ready);
    assign in_fire     = bus.in_valid && in_ready_c;

    always_comb begin
        state_d = state_q;
        if (in_fire)
            state_d = S_HELD;
        else if (issue || flush)
            state_d = S_EMPTY;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= S_EMPTY;
        else
            state_q <= state_d;
    end

    // Held instruction fields carry no reset; stage-valid alone qualifies them.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            pc_q        <= bus.in_pc;
            src1_en_q   <= bus.in_src1_en;
            src2_en_q   <= bus.in_src2_en;
            src1_addr_q <= bus.in_src1_addr;
            src2_addr_q <= bus.in_src2_addr;
            dst_addr_q  <= bus.in_dst_addr;
            dst_we_q    <= bus.in_dst_we;
        end
    end

    // Pending-write scoreboard; a release on an empty counter is dropped.
    assign inc_hit = issue && dst_we_q && (dst_addr_q != '0);
    assign dec_hit = wb_release && (wb_addr != '0) && (cnt_q[wb_addr] != '0);

    always_comb begin
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r != 0) begin
                if (inc_hit && dst_addr_q == AW'(r) && !(dec_hit && wb_addr == AW'(r)))
                    cnt_d[r] = cnt_q[r] + CNT_W'(1);
                else if (dec_hit && wb_addr == AW'(r) && !(inc_hit && dst_addr_q == AW'(r)))
                    cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++)
                cnt_q[r] <= cnt_d[r];
        end
    end

    assign rf_raddr1        = src1_addr_q;
    assign rf_raddr2        = src2_addr_q;
    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_c;
    assign bus.out_pc       = pc_q;
    assign bus.out_src1     = src_val[0];
    assign bus.out_src2     = src_val[1];
    assign bus.out_dst_we   = dst_we_q;
    assign bus.out_dst_addr = dst_addr_q;
endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: directed hazard/forwarding scenarios plus random traffic,
// checked against a queue-of-pending-writes reference model.
module tb_id_issue_ctrl;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned AW     = 5;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned NFWD   = 3;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    id_issue_ctrl_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    logic [AW-1:0]          rf_raddr1, rf_raddr2;
    logic [DATA_W-1:0]      rf_rdata1, rf_rdata2;
    logic [NFWD-1:0]        fwd_valid, fwd_ready;
    logic [NFWD*AW-1:0]     fwd_addr;
    logic [NFWD*DATA_W-1:0] fwd_data;
    logic                   wb_release;
    logic [AW-1:0]          wb_addr;
    logic                   flush;

    id_issue_ctrl #(.DATA_W(DATA_W), .AW(AW), .CNT_W(CNT_W), .NFWD(NFWD)) dut (
        .clk(clk), .resetn(resetn), .bus(bus),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wb_release(wb_release), .wb_addr(wb_addr), .flush(flush)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: held instruction plus list of writes issued but not yet released.
    bit          m_v = 1'b0;
    logic [31:0] m_pc;
    bit          m_s1en, m_s2en, m_we;
    logic [4:0]  m_s1, m_s2, m_dst;
    int          pend[$];
    bit          e_rg, e_ov, e_ir, e_issue;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pending_of(input logic [4:0] a);
        int n = 0;
        foreach (pend[k]) if (pend[k] == int'(a)) n++;
        return n;
    endfunction

    function automatic int fwd_match(input logic [4:0] a);
        for (int i = 0; i < int'(NFWD); i++)
            if (fwd_valid[i] && fwd_addr[i*AW +: AW] == a) return i;
        return -1;
    endfunction

    function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] rf);
        int p;
        if (a == 0) return 32'h0;
        p = fwd_match(a);
        if (p >= 0) return fwd_data[p*DATA_W +: DATA_W];
        return rf;
    endfunction

    function automatic bit blocked(input bit en, input logic [4:0] a);
        int p;
        if (!en || a == 0) return 1'b0;
        p = fwd_match(a);
        if (p >= 0) return !fwd_ready[p];
        return pending_of(a) != 0;
    endfunction

    task automatic settle();
        #1;
        e_rg = m_v && !blocked(m_s1en, m_s1) && !blocked(m_s2en, m_s2) &&
               !(m_we && m_dst != 0 && pending_of(m_dst) == CMAX);
        e_ov    = e_rg && !flush;
        e_ir    = !m_v || (e_rg && bus.out_ready);
        e_issue = e_ov && bus.out_ready;
        check_eq("out_valid", 64'(bus.out_valid), 64'(e_ov));
        check_eq("in_ready",  64'(bus.in_ready),  64'(e_ir));
        if (m_v) begin
            check_eq("rf_raddr1", 64'(rf_raddr1), 64'(m_s1));
            check_eq("rf_raddr2", 64'(rf_raddr2), 64'(m_s2));
        end
        if (e_ov) begin
            check_eq("out_pc",       64'(bus.out_pc),       64'(m_pc));
            check_eq("out_src1",     64'(bus.out_src1),     64'(resolve(m_s1, rf_rdata1)));
            check_eq("out_src2",     64'(bus.out_src2),     64'(resolve(m_s2, rf_rdata2)));
            check_eq("out_dst_we",   64'(bus.out_dst_we),   64'(m_we));
            check_eq("out_dst_addr", 64'(bus.out_dst_addr), 64'(m_dst));
        end
    endtask

    task automatic advance();
        if (wb_release && wb_addr != 0) begin
            for (int k = 0; k < pend.size(); k++)
                if (pend[k] == int'(wb_addr)) begin pend.delete(k); break; end
        end
        if (e_issue && m_we && m_dst != 0) pend.push_back(int'(m_dst));
        if (bus.in_valid && e_ir) begin
            m_v = 1'b1; m_pc = bus.in_pc; m_we = bus.in_dst_we; m_dst = bus.in_dst_addr;
            m_s1en = bus.in_src1_en; m_s2en = bus.in_src2_en;
            m_s1 = bus.in_src1_addr; m_s2 = bus.in_src2_addr;
        end else if (e_issue || flush) begin
            m_v = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        advance();
    endtask

    task automatic idle();
        bus.in_valid = 0; bus.in_pc = '0; bus.in_src1_en = 0; bus.in_src2_en = 0;
        bus.in_src1_addr = '0; bus.in_src2_addr = '0; bus.in_dst_addr = '0; bus.in_dst_we = 0;
        bus.out_ready = 1;
        fwd_valid = '0; fwd_ready = '0; fwd_addr = '0; fwd_data = '0;
        rf_rdata1 = '0; rf_rdata2 = '0; wb_release = 0; wb_addr = '0; flush = 0;
    endtask

    task automatic load(input logic [31:0] pc, input bit s1en, input logic [4:0] s1,
                        input bit s2en, input logic [4:0] s2, input bit we, input logic [4:0] dst);
        bus.in_valid = 1; bus.in_pc = pc;
        bus.in_src1_en = s1en; bus.in_src1_addr = s1;
        bus.in_src2_en = s2en; bus.in_src2_addr = s2;
        bus.in_dst_we = we; bus.in_dst_addr = dst;
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 64 && pend.size() > 0; k++) begin
            wb_release = 1; wb_addr = AW'(pend[0]);
            step();
        end
        idle();
        repeat (3) step();
        check_eq("drain_empty", 64'(pend.size()), 64'd0);
    endtask

    task automatic set_fwd(input int p, input logic [4:0] a, input bit rdy, input logic [31:0] d);
        fwd_valid[p] = 1'b1; fwd_ready[p] = rdy;
        fwd_addr[p*AW +: AW] = a; fwd_data[p*DATA_W +: DATA_W] = d;
    endtask

    initial begin
        idle();
        resetn = 0;
        repeat (2) @(negedge clk);
        settle();
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
        resetn = 1;

        // Forward from EX with no stall cycle.
        load(32'h100, 0, 0, 0, 0, 1, 4); step();
        load(32'h104, 1, 4, 0, 0, 1, 6); step();
        bus.in_valid = 0; set_fwd(0, 4, 1, 32'h1234);
        settle();
        check_eq("fwd_ex_src1", 64'(bus.out_src1), 64'h1234);
        check_eq("fwd_ex_ov",   64'(bus.out_valid), 64'd1);
        advance();
        drain();

        // Load-use: one bubble, then data from port 1.
        load(32'h200, 0, 0, 0, 0, 1, 4); step();
        load(32'h204, 1, 4, 0, 0, 0, 0); step();
        bus.in_valid = 0; set_fwd(0, 4, 0, 32'h0);
        settle(); check_eq("loaduse_stall", 64'(bus.out_valid), 64'd0); advance();
        fwd_valid = '0; set_fwd(1, 4, 1, 32'h5555);
        settle();
        check_eq("loaduse_go",   64'(bus.out_valid), 64'd1);
        check_eq("loaduse_src1", 64'(bus.out_src1), 64'h5555);
        advance();
        drain();

        // Youngest-port priority and r0 forced to zero.
        load(32'h300, 1, 7, 1, 0, 0, 0); step();
        bus.in_valid = 0;
        set_fwd(0, 7, 1, 32'hA); set_fwd(1, 0, 1, 32'hC); set_fwd(2, 7, 1, 32'hB);
        rf_rdata2 = 32'hDEAD;
        settle();
        check_eq("prio_src1", 64'(bus.out_src1), 64'hA);
        check_eq("r0_src2",   64'(bus.out_src2), 64'h0);
        advance();
        drain();

        // Counter saturation on r5.
        for (int i = 0; i < 4; i++) begin
            load(32'h400 + 32'(4*i), 0, 0, 0, 0, 1, 5); step();
        end
        bus.in_valid = 0;
        settle(); check_eq("sat_stall", 64'(bus.out_valid), 64'd0); advance();
        wb_release = 1; wb_addr = 5;
        settle(); check_eq("sat_rel_cycle", 64'(bus.out_valid), 64'd0); advance();
        wb_release = 0;
        settle(); check_eq("sat_issue", 64'(bus.out_valid), 64'd1); advance();
        drain();

        // Flush while hazard-stalled, then simultaneous issue and release on r3.
        load(32'h500, 0, 0, 0, 0, 1, 3); step();
        load(32'h504, 1, 3, 0, 0, 0, 0); step();
        bus.in_valid = 0;
        settle(); check_eq("haz_stall", 64'(bus.out_valid), 64'd0); advance();
        flush = 1;
        settle(); check_eq("flush_ov", 64'(bus.out_valid), 64'd0); advance();
        flush = 0;
        settle(); check_eq("flush_cleared", 64'(bus.in_ready), 64'd1); advance();
        load(32'h508, 0, 0, 0, 0, 1, 3); step();
        bus.in_valid = 0; wb_release = 1; wb_addr = 3;
        settle(); check_eq("issue_rel_ov", 64'(bus.out_valid), 64'd1); advance();
        wb_release = 0;
        load(32'h50C, 1, 3, 0, 0, 0, 0); step();
        bus.in_valid = 0;
        settle(); check_eq("cnt_kept_stall", 64'(bus.out_valid), 64'd0); advance();
        drain();

        // Asynchronous reset with counters nonzero.
        load(32'h600, 0, 0, 0, 0, 1, 9); step();
        load(32'h604, 0, 0, 0, 0, 1, 10); step();
        load(32'h608, 1, 9, 1, 10, 0, 0); step();
        bus.in_valid = 0;
        settle(); check_eq("pre_rst_stall", 64'(bus.out_valid), 64'd0);
        #1 resetn = 0;
        #1;
        check_eq("async_rst_ov", 64'(bus.out_valid), 64'd0);
        check_eq("async_rst_ir", 64'(bus.in_ready),  64'd1);
        pend.delete(); m_v = 1'b0;
        @(negedge clk);
        resetn = 1;
        idle();
        load(32'h60C, 1, 9, 1, 10, 0, 0); step();
        bus.in_valid = 0;
        settle(); check_eq("post_rst_issue", 64'(bus.out_valid), 64'd1); advance();

        // Random traffic over a small register window to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid     = ($urandom % 10) < 7;
            bus.in_pc        = $urandom;
            bus.in_src1_en   = $urandom % 2;
            bus.in_src2_en   = $urandom % 2;
            bus.in_src1_addr = AW'($urandom_range(0, 7));
            bus.in_src2_addr = AW'($urandom_range(0, 7));
            bus.in_dst_addr  = AW'($urandom_range(0, 7));
            bus.in_dst_we    = ($urandom % 4) != 0;
            bus.out_ready    = ($urandom % 10) < 7;
            flush            = ($urandom % 10) == 0;
            rf_rdata1        = $urandom;
            rf_rdata2        = $urandom;
            fwd_valid = '0; fwd_ready = '0;
            for (int p = 0; p < int'(NFWD); p++)
                if ($urandom % 2) set_fwd(p, 5'($urandom_range(0, 7)), ($urandom % 4) != 0, $urandom);
            if (pend.size() > 0 && ($urandom % 10) < 4) begin
                wb_release = 1;
                wb_addr    = AW'(pend[$urandom_range(0, pend.size() - 1)]);
            end else begin
                wb_release = 0;
                wb_addr    = '0;
            end
            step();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
